// File: rtl/kbd_pkg.sv
// kbd_pkg -- shared types and helpers for the PS/2-to-matrix keyboard.
//   op_e        : autotype script opcodes
//   row_w/col_w : field widths of a script entry
//   ent_w       : full script entry width {op, row, col}
//   SC_*        : PS/2 set-2 scan codes of the modifier keys
//   kmap_t      : keymap lookup result {hit, row, col}
package kbd_pkg;

    typedef enum logic [1:0] {
        OP_END     = 2'b00,
        OP_PRESS   = 2'b01,
        OP_RELEASE = 2'b10,
        OP_WAIT    = 2'b11
    } op_e;

    // Row field also has to address the modifier row (index ROWS).
    function automatic int row_w(input int rows);
        return $clog2(rows + 1);
    endfunction

    function automatic int col_w(input int cols);
        return $clog2(cols);
    endfunction

    function automatic int ent_w(input int rows, input int cols);
        return 2 + row_w(rows) + col_w(cols);
    endfunction

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef struct packed {
        logic       hit;
        logic [7:0] row;
        logic [7:0] col;
    } kmap_t;

endpackage

// File: rtl/kbd_keymap.sv
// kbd_keymap -- combinational PS/2 scan code to matrix position table.
//   ext  : extended-code flag (E0 prefix seen)
//   code : 8-bit set-2 scan code
//   km   : {hit, row, col}; modifier keys land on row ROWS
module kbd_keymap
    import kbd_pkg::*;
#(
    parameter int ROWS = 8
) (
    input  logic       ext,
    input  logic [7:0] code,
    output kmap_t      km
);

    logic is_mod;

    always_comb begin
        km        = '0;
        km.hit    = 1'b1;
        is_mod    = 1'b0;
        case ({ext, code})
            9'h01C: begin km.row = 8'd4; km.col = 8'd1; end // A
            9'h05A: begin km.row = 8'd1; km.col = 8'd2; end // Enter
            9'h029: begin km.row = 8'd7; km.col = 8'd7; end // Space
            9'h01B: begin km.row = 8'd1; km.col = 8'd5; end // S
            9'h023: begin km.row = 8'd2; km.col = 8'd2; end // D
            9'h02B: begin km.row = 8'd2; km.col = 8'd5; end // F
            9'h015: begin km.row = 8'd7; km.col = 8'd6; end // Q
            9'h01D: begin km.row = 8'd1; km.col = 8'd1; end // W
            9'h024: begin km.row = 8'd1; km.col = 8'd6; end // E
            9'h02D: begin km.row = 8'd2; km.col = 8'd1; end // R
            9'h016: begin km.row = 8'd7; km.col = 8'd0; end // 1
            9'h01E: begin km.row = 8'd7; km.col = 8'd3; end // 2
            9'h045: begin km.row = 8'd4; km.col = 8'd3; end // 0
            9'h066: begin km.row = 8'd0; km.col = 8'd0; end // Backspace
            9'h174: begin km.row = 8'd0; km.col = 8'd2; end // Right arrow
            9'h172: begin km.row = 8'd0; km.col = 8'd7; end // Down arrow
            {1'b0, SC_LSHIFT}, {1'b0, SC_RSHIFT}: begin
                km.row = 8'(ROWS); km.col = 8'd0; is_mod = 1'b1;
            end
            {1'b0, SC_CTRL}, {1'b1, SC_CTRL}: begin
                km.row = 8'(ROWS); km.col = 8'd1; is_mod = 1'b1;
            end
            {1'b0, SC_CAPS}: begin
                km.row = 8'(ROWS); km.col = 8'd2; is_mod = 1'b1;
            end
            default: km.hit = 1'b0;
        endcase
        // A smaller matrix drops ordinary keys whose row does not exist.
        if (!is_mod && (int'(km.row) >= ROWS))
            km.hit = 1'b0;
    end

endmodule

// File: rtl/ps2_matrix_kbd.sv
// ps2_matrix_kbd -- PS/2 key events to a scannable key matrix, with an
// optional timed autotype script (built when KBD_AUTOTYPE_EN is defined).
//   clk, reset_n      : clock, async active-low reset
//   ps2_key[10:0]     : {toggle, pressed, ext, code}
//   scan_sel/scan_data: row select in, OR of selected rows out (1 = down)
//   mods              : low MOD_W bits of the modifier row (row ROWS)
//   auto_start/busy   : script launch request / script running
//   scr_we/addr/data  : script write port, entry = {op, row, col}
module ps2_matrix_kbd
    import kbd_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int MOD_W      = 3,
    parameter int TICK_DIV   = 7000000,
    parameter int SCRIPT_LEN = 32,
    localparam int AW        = $clog2(SCRIPT_LEN),
    localparam int ENT_W     = ent_w(ROWS, COLS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      ps2_key,
    input  logic [ROWS-1:0]  scan_sel,
    output logic [COLS-1:0]  scan_data,
    output logic [MOD_W-1:0] mods,
    input  logic             auto_start,
    output logic             auto_busy,
    input  logic             scr_we,
    input  logic [AW-1:0]    scr_addr,
    input  logic [ENT_W-1:0] scr_data
);

    localparam int RW = row_w(ROWS);
    localparam int CW = col_w(COLS);

    kmap_t km;
    kbd_keymap #(.ROWS(ROWS)) u_keymap (
        .ext  (ps2_key[8]),
        .code (ps2_key[7:0]),
        .km   (km)
    );

    logic [ROWS:0][COLS-1:0] mat_q, mat_d;
    logic                    tog_q, tog_d;
    logic                    ps2_evt, key_ok, ps2_ok;

    assign ps2_evt = ps2_key[10] ^ tog_q;
    assign key_ok  = km.hit && (int'(km.row) <= ROWS) && (int'(km.col) < COLS);

    always_comb begin
        scan_data = '0;
        for (int r = 0; r < ROWS; r++)
            if (scan_sel[r]) scan_data = scan_data | mat_q[r];
    end

    assign mods = mat_q[ROWS][MOD_W-1:0];

`ifdef KBD_AUTOTYPE_EN
    localparam int DW = $clog2(TICK_DIV);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e                            state_q, state_d;
    logic [AW-1:0]                     ptr_q, ptr_d;
    logic [DW-1:0]                     div_q, div_d;
    logic [SCRIPT_LEN-1:0][ENT_W-1:0]  scr_q, scr_d;
    logic [ENT_W-1:0]                  ent;
    op_e                               e_op;
    logic [RW-1:0]                     e_row;
    logic [CW-1:0]                     e_col;
    logic                              ecol_ok, tick;

    assign ent   = scr_q[ptr_q];
    assign e_op  = op_e'(ent[ENT_W-1 -: 2]);
    assign e_row = ent[CW +: RW];
    assign e_col = ent[CW-1:0];
    assign tick  = (div_q == DW'(TICK_DIV - 1));

    // A column field that exactly spans COLS can never be out of range.
    if ((1 << CW) == COLS) begin : g_col_full
        assign ecol_ok = 1'b1;
    end else begin : g_col_part
        assign ecol_ok = (int'(e_col) < COLS);
    end

    assign ps2_ok    = (state_q == S_IDLE);
    assign auto_busy = (state_q == S_RUN);

    always_comb begin
        mat_d   = mat_q;
        tog_d   = ps2_key[10];
        state_d = state_q;
        ptr_d   = ptr_q;
        div_d   = div_q;
        scr_d   = scr_q;
        case (state_q)
            S_IDLE: begin
                if (scr_we) scr_d[scr_addr] = scr_data;
                if (auto_start) begin
                    state_d    = S_RUN;
                    ptr_d      = '0;
                    div_d      = '0;
                    mat_d[ROWS] = '0;
                end
            end
            S_RUN: begin
                if (tick) begin
                    div_d = '0;
                    ptr_d = ptr_q + AW'(1);
                    if ((e_op == OP_PRESS || e_op == OP_RELEASE) &&
                        (int'(e_row) <= ROWS) && ecol_ok)
                        mat_d[e_row][e_col] = (e_op == OP_PRESS);
                    // Running off the last entry behaves like END.
                    if (e_op == OP_END || ptr_q == AW'(SCRIPT_LEN - 1)) begin
                        mat_d   = '0;
                        state_d = S_IDLE;
                        ptr_d   = '0;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Applied after the modifier-row clear so a same-cycle event survives.
        if (ps2_ok && ps2_evt && key_ok)
            mat_d[km.row[RW-1:0]][km.col[CW-1:0]] = ps2_key[9];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            div_q   <= '0;
            scr_q   <= '0; // all-zero entry is END
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            div_q   <= div_d;
            scr_q   <= scr_d;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = ^{auto_start, scr_we, scr_addr, scr_data};
    assign ps2_ok      = 1'b1;
    assign auto_busy   = 1'b0;

    always_comb begin
        mat_d = mat_q;
        tog_d = ps2_key[10];
        if (ps2_ok && ps2_evt && key_ok)
            mat_d[km.row[RW-1:0]][km.col[CW-1:0]] = ps2_key[9];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mat_q <= '0;
            tog_q <= 1'b0;
        end else begin
            mat_q <= mat_d;
            tog_q <= tog_d;
        end
    end

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Self-checking bench for ps2_matrix_kbd (ROWS=8, COLS=8, TICK_DIV=4,
// SCRIPT_LEN=8). Directed checks plus a randomized PS/2 phase checked
// against a bit-array model; script checks only when KBD_AUTOTYPE_EN.
module tb_ps2_matrix_kbd;

    localparam int ROWS = 8, COLS = 8, MOD_W = 3, TICK_DIV = 4, SLEN = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [7:0]  scan_sel = '0;
    logic [7:0]  scan_data;
    logic [2:0]  mods;
    logic        auto_start = 1'b0;
    logic        auto_busy;
    logic        scr_we = 1'b0;
    logic [2:0]  scr_addr = '0;
    logic [8:0]  scr_data = '0;

    int ncmp = 0, nbad = 0;
    logic [7:0] ref_m [0:8];

    ps2_matrix_kbd #(
        .ROWS(ROWS), .COLS(COLS), .MOD_W(MOD_W),
        .TICK_DIV(TICK_DIV), .SCRIPT_LEN(SLEN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
        .scan_sel(scan_sel), .scan_data(scan_data), .mods(mods),
        .auto_start(auto_start), .auto_busy(auto_busy),
        .scr_we(scr_we), .scr_addr(scr_addr), .scr_data(scr_data)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive scan_sel and check scan_data against a given value.
    task automatic look(input string tag, input logic [7:0] sel, input logic [7:0] exp);
        scan_sel = sel; #1;
        chk(tag, {24'd0, scan_data}, {24'd0, exp});
    endtask

    // Keymap positions as stated for the known keys; anything else misses.
    task automatic ref_map(input logic ext, input logic [7:0] code,
                           output bit hit, output int r, output int c);
        hit = 1; r = 0; c = 0;
        case ({ext, code})
            9'h01C: begin r = 4; c = 1; end
            9'h05A: begin r = 1; c = 2; end
            9'h029: begin r = 7; c = 7; end
            9'h012, 9'h059: begin r = ROWS; c = 0; end
            9'h014: begin r = ROWS; c = 1; end
            9'h058: begin r = ROWS; c = 2; end
            default: hit = 0;
        endcase
    endtask

    function automatic logic [7:0] ref_scan(input logic [7:0] sel);
        logic [7:0] v = '0;
        for (int r = 0; r < ROWS; r++) if (sel[r]) v |= ref_m[r];
        return v;
    endfunction

    task automatic clear_ref();
        for (int r = 0; r <= ROWS; r++) ref_m[r] = '0;
    endtask

    // Issue one PS/2 event (takes one clock) and track it in the model.
    task automatic ps2(input logic pressed, input logic ext, input logic [7:0] code);
        bit hit; int r, c;
        ps2_key = {~ps2_key[10], pressed, ext, code};
        step();
        ref_map(ext, code, hit, r, c);
        if (hit) ref_m[r][c] = pressed;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] sel;
        sel = 8'($urandom);
        look(tag, sel, ref_scan(sel));
        chk({tag, "_mods"}, {29'd0, mods}, {29'd0, ref_m[ROWS][2:0]});
    endtask

    task automatic wr(input int a, input logic [1:0] op, input int r, input int c);
        scr_we = 1'b1; scr_addr = 3'(a); scr_data = {op, 4'(r), 3'(c)};
        step();
        scr_we = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; #1;
        reset_n = 1'b1; step();
        clear_ref();
    endtask

    logic [7:0] codes [0:9];
    logic       exts  [0:9];

    initial begin
        codes = '{8'h1C, 8'h5A, 8'h29, 8'h12, 8'h59, 8'h14, 8'h58, 8'h00, 8'h7F, 8'h1C};
        exts  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_ref();

        // Reset state
        #2 reset_n = 1'b0; scan_sel = 8'hFF; #1;
        chk("rst_scan", {24'd0, scan_data}, 32'd0);
        chk("rst_mods", {29'd0, mods}, 32'd0);
        chk("rst_busy", {31'd0, auto_busy}, 32'd0);
        step(2);
        reset_n = 1'b1;
        step();

        // Single key
        ps2(1'b1, 1'b0, 8'h1C);
        look("a_row4", 8'h10, 8'h02);
        look("a_other", 8'hEF, 8'h00);
        ps2(1'b0, 1'b0, 8'h1C);
        look("a_rel", 8'h10, 8'h00);

        // Modifiers: both shifts share one bit
        ps2(1'b1, 1'b0, 8'h12);
        ps2(1'b1, 1'b0, 8'h14);
        chk("mods_011", {29'd0, mods}, 32'd3);
        ps2(1'b0, 1'b0, 8'h59);
        chk("mods_010", {29'd0, mods}, 32'd2);
        ps2(1'b0, 1'b0, 8'h14);
        chk("mods_000", {29'd0, mods}, 32'd0);

        // Unchanged toggle means no event even if the code changes
        ps2_key = {ps2_key[10], 1'b1, 1'b0, 8'h29};
        step();
        look("no_toggle", 8'h80, 8'h00);

        // Randomized PS/2 traffic against the model
        for (int i = 0; i < 120; i++) begin
            int k = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) step();
            else ps2(1'($urandom_range(0, 1)), exts[k], codes[k]);
            check_model("rand");
        end

`ifdef KBD_AUTOTYPE_EN
        do_reset();
        // Script run, with a held modifier cleared on entry to RUN
        wr(0, 2'b01, 6, 2); wr(1, 2'b10, 6, 2); wr(2, 2'b00, 0, 0);
        ps2(1'b1, 1'b0, 8'h12);
        chk("pre_mods", {29'd0, mods}, 32'd1);
        auto_start = 1'b1; step(); auto_start = 1'b0;            // E0
        chk("run_busy0", {31'd0, auto_busy}, 32'd1);
        chk("run_modclr", {29'd0, mods}, 32'd0);
        step(3); look("run_e3", 8'h40, 8'h00);
        step(1); look("run_e4", 8'h40, 8'h04);
        step(3); look("run_e7", 8'h40, 8'h04);
        step(1); look("run_e8", 8'h40, 8'h00);
        step(3); chk("run_e11", {31'd0, auto_busy}, 32'd1);
        step(1); chk("run_e12", {31'd0, auto_busy}, 32'd0);

        // Lockout: same-cycle key + start, then key, start and write while busy
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
        auto_start = 1'b1; step(); auto_start = 1'b0;            // E0
        chk("same_busy", {31'd0, auto_busy}, 32'd1);
        look("same_key", 8'h10, 8'h02);
        step(2);                                                 // E2
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h29};
        scr_we = 1'b1; scr_addr = 3'd1; scr_data = 9'd0;
        step(); scr_we = 1'b0;                                   // E3
        step(1); look("lock_e4", 8'hC0, 8'h04);                  // E4
        step(1); auto_start = 1'b1; step(); auto_start = 1'b0;   // E6
        step(2); look("lock_e8", 8'hC0, 8'h00);                  // E8
        step(3); chk("lock_e11", {31'd0, auto_busy}, 32'd1);
        step(1); chk("lock_e12", {31'd0, auto_busy}, 32'd0);
        look("lock_endclr", 8'hFF, 8'h00);
        step(2);
        chk("lock_idle", {31'd0, auto_busy}, 32'd0);
        ps2(1'b1, 1'b0, 8'h29);
        look("post_space", 8'h80, 8'h80);
        ps2(1'b0, 1'b0, 8'h29);

        // Abort mid-script, then restart from entry 0
        auto_start = 1'b1; step(); auto_start = 1'b0;            // E0
        step(4); look("abort_e4", 8'h40, 8'h04);
        step(1);                                                 // E5
        reset_n = 1'b0; #1;
        chk("abort_busy", {31'd0, auto_busy}, 32'd0);
        look("abort_mat", 8'hFF, 8'h00);
        chk("abort_mods", {29'd0, mods}, 32'd0);
        step(); reset_n = 1'b1; step();
        wr(0, 2'b01, 6, 2); wr(1, 2'b10, 6, 2); wr(2, 2'b00, 0, 0);
        auto_start = 1'b1; step(); auto_start = 1'b0;
        step(3); look("restart_e3", 8'h40, 8'h00);
        step(1); look("restart_e4", 8'h40, 8'h04);
        step(8); chk("restart_e12", {31'd0, auto_busy}, 32'd0);

        // Exhaustion, out-of-range row, script write to the modifier row
        wr(0, 2'b01, 1, 1); wr(1, 2'b01, 9, 0); wr(2, 2'b01, 8, 2);
        for (int a = 3; a < 7; a++) wr(a, 2'b11, 0, 0);
        wr(7, 2'b01, 3, 3);
        auto_start = 1'b1; step(); auto_start = 1'b0;            // E0
        step(4);  look("ex_e4", 8'hFF, 8'h02);
        step(4);  look("ex_e8", 8'hFF, 8'h02);
        chk("ex_e8_mods", {29'd0, mods}, 32'd0);
        step(4);  chk("ex_e12_mods", {29'd0, mods}, 32'd4);
        step(16); look("ex_e28", 8'hFF, 8'h02);
        step(3);  chk("ex_e31", {31'd0, auto_busy}, 32'd1);
        step(1);  chk("ex_e32", {31'd0, auto_busy}, 32'd0);
        look("ex_clr", 8'hFF, 8'h00);
        chk("ex_clr_mods", {29'd0, mods}, 32'd0);
`else
        do_reset();
        ps2(1'b1, 1'b0, 8'h5A);
        wr(0, 2'b01, 6, 2);
        auto_start = 1'b1; step(); auto_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("noauto_busy", {31'd0, auto_busy}, 32'd0);
            check_model("noauto");
            step();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
